// File: rtl/force_arb_pkg.sv
// -----------------------------------------------------------------------------
// force_arb_pkg
// Shared types and constants for the force/override arbiter.
//   arb_state_e  : controller states (IDLE / FORCED / RELEASE)
//   owner_idx_t  : owner index sized for the largest supported requester count
//   HOLD_CNT_W   : hold counter width for the default minimum hold
//   cnt_width()  : hold counter width for any HOLD_MIN, $clog2(HOLD_MIN+1)
// -----------------------------------------------------------------------------
package force_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORCED  = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int MAX_NREQ    = 8;
    localparam int OWNER_W_MAX = $clog2(MAX_NREQ);

    typedef logic [OWNER_W_MAX-1:0] owner_idx_t;

    localparam int HOLD_MIN_DEFAULT = 2;
    localparam int HOLD_CNT_W       = $clog2(HOLD_MIN_DEFAULT + 1);

    // The counter must be able to hold the value HOLD_MIN itself, since it
    // saturates there.
    function automatic int cnt_width(input int hold_min);
        return (hold_min < 1) ? 1 : $clog2(hold_min + 1);
    endfunction

endpackage

// File: rtl/force_override_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req starting one position after
// 'last', wrapping modulo NREQ (works for non-power-of-2 NREQ).
//   req  : request vector
//   last : index of the previous winner (lowest priority on this pick)
//   any  : at least one request is set
//   sel  : index of the winning request (0 when any=0)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] sel
);

    // Walk offsets from farthest to nearest so the nearest set request after
    // 'last' is the final assignment and therefore wins.
    always_comb begin
        any = 1'b0;
        sel = '0;
        for (int off = NREQ; off >= 1; off--) begin
            for (int j = 0; j < NREQ; j++) begin
                if (req[j] && (j == ((int'(last) + off) % NREQ))) begin
                    any = 1'b1;
                    sel = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/force_override_arb.sv
// -----------------------------------------------------------------------------
// force_override_arb
// Arbitrated override of a register-backed output. Requesters compete to force
// their value onto 'out'; the owner holds it for at least HOLD_MIN cycles, then
// a one-cycle RELEASE state shows the natural value before the next grant.
//   clk, rst_n : clock, asynchronous active-low reset
//   nat_in     : natural value, passed straight through when not forced
//   req, rel   : level request / release per requester
//   val        : packed force values, requester i at [i*WIDTH +: WIDTH]
//   gnt        : one-hot owner while forced, else zero
//   forced     : override active
//   owner      : current or last owner index
//   out        : forced ? forced value : nat_in
// -----------------------------------------------------------------------------
module force_override_arb
    import force_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 4,
    parameter int HOLD_MIN = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        nat_in,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         rel,
    input  logic [NREQ*WIDTH-1:0]   val,
    output logic [NREQ-1:0]         gnt,
    output logic                    forced,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic [WIDTH-1:0]        out
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = cnt_width(HOLD_MIN);

    arb_state_e        state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              forced_q, forced_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0]  fval_q, fval_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic              rel_pend_q, rel_pend_d;

    logic [WIDTH-1:0]  val_arr [NREQ];
    logic              pick_any;
    logic [IDX_W-1:0]  pick_sel;
    logic              own_req, own_rel;
    logic              hold_ok, rel_fire;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            val_arr[i] = val[i*WIDTH +: WIDTH];
        end
    end

    // ptr_q is kept apart from owner_q so that reset can give req[0] top
    // priority while still reporting owner=0.
    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req  (req),
        .last (ptr_q),
        .any  (pick_any),
        .sel  (pick_sel)
    );

    assign own_req  = req[owner_q];
    assign own_rel  = rel[owner_q];
    // Signed compare keeps HOLD_MIN=1 (always ok) free of constant-compare issues.
    assign hold_ok  = (int'(hold_cnt_q) + 1) >= HOLD_MIN;
    // A release seen too early is remembered in rel_pend_q and honoured later.
    assign rel_fire = (own_rel || rel_pend_q) && hold_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            forced_q   <= 1'b0;
            owner_q    <= '0;
            ptr_q      <= IDX_W'(NREQ - 1);
            fval_q     <= '0;
            hold_cnt_q <= '0;
            rel_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            forced_q   <= forced_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            fval_q     <= fval_d;
            hold_cnt_q <= hold_cnt_d;
            rel_pend_q <= rel_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = FORCED;
            FORCED:  if (rel_fire) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d      = gnt_q;
        forced_d   = forced_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        fval_d     = fval_q;
        hold_cnt_d = hold_cnt_q;
        rel_pend_d = rel_pend_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    fval_d     = val_arr[pick_sel];
                    owner_d    = pick_sel;
                    ptr_d      = pick_sel;
                    gnt_d      = NREQ'(1) << pick_sel;
                    forced_d   = 1'b1;
                    hold_cnt_d = '0;
                    rel_pend_d = 1'b0;
                end
            end
            FORCED: begin
                if (int'(hold_cnt_q) < HOLD_MIN) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
                if (rel_fire) begin
                    gnt_d    = '0;
                    forced_d = 1'b0;
                end else if (own_rel) begin
                    // Release beats re-force when both are high.
                    rel_pend_d = 1'b1;
                end else if (own_req) begin
                    fval_d = val_arr[owner_q];
                end
            end
            RELEASE: begin
                gnt_d      = '0;
                forced_d   = 1'b0;
                rel_pend_d = 1'b0;
            end
            default: begin
                gnt_d    = '0;
                forced_d = 1'b0;
            end
        endcase
    end

    assign gnt    = gnt_q;
    assign forced = forced_q;
    assign owner  = owner_q;
    assign out    = forced_q ? fval_q : nat_in;

endmodule

// File: tb/tb_force_override_arb.sv
// -----------------------------------------------------------------------------
// tb_force_override_arb
// Drives two arbiters (NREQ=4/HOLD_MIN=2 and NREQ=3/HOLD_MIN=1) with directed
// then random traffic and compares every cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_force_override_arb;

    logic        clk;
    logic        rst_n;

    logic [3:0]  nat4, req4, rel4, gnt4, out4;
    logic [15:0] val4;
    logic        forced4;
    logic [1:0]  owner4;

    logic [3:0]  nat3, out3;
    logic [2:0]  req3, rel3, gnt3;
    logic [11:0] val3;
    logic        forced3;
    logic [1:0]  owner3;

    int compared;
    int mismatched;

    typedef struct {
        bit active;
        bit gap;
        int owner;
        int last;
        int fval;
        int age;
        bit pend;
    } mdl_t;

    mdl_t m4, m3;

    force_override_arb #(.NREQ(4), .WIDTH(4), .HOLD_MIN(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .nat_in(nat4), .req(req4), .rel(rel4),
        .val(val4), .gnt(gnt4), .forced(forced4), .owner(owner4), .out(out4)
    );

    force_override_arb #(.NREQ(3), .WIDTH(4), .HOLD_MIN(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .nat_in(nat3), .req(req3), .rel(rel3),
        .val(val3), .gnt(gnt3), .forced(forced3), .owner(owner3), .out(out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mdl_t mreset(input int nreq);
        mdl_t n;
        n.active = 0; n.gap = 0; n.owner = 0; n.last = nreq - 1;
        n.fval = 0; n.age = 0; n.pend = 0;
        return n;
    endfunction

    // One clock edge of the arbiter, written from its behavioural rules:
    // one-cycle gap after a release, round-robin pick after the last owner,
    // minimum hold measured in forced edges, release wins over re-force.
    function automatic mdl_t mstep(input mdl_t m, input int nreq, input int hmin,
                                   input int rq[8], input int rl[8], input int vv[8]);
        mdl_t n;
        bit found;
        n = m;
        found = 0;
        if (m.gap) begin
            n.gap = 0;
            n.pend = 0;
        end else if (!m.active) begin
            for (int k = 1; k <= nreq; k++) begin
                if (!found && rq[(m.last + k) % nreq] != 0) begin
                    found = 1;
                    n.owner = (m.last + k) % nreq;
                    n.last = n.owner;
                    n.active = 1;
                    n.fval = vv[n.owner];
                    n.age = 0;
                    n.pend = 0;
                end
            end
        end else if ((rl[m.owner] != 0 || m.pend) && (m.age + 1 >= hmin)) begin
            n.active = 0;
            n.gap = 1;
        end else begin
            n.age = m.age + 1;
            if (rl[m.owner] != 0) n.pend = 1;
            else if (rq[m.owner] != 0) n.fval = vv[m.owner];
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("dut4.forced", 32'(forced4), 32'(m4.active));
        check("dut4.gnt",    32'(gnt4),    m4.active ? (32'd1 << m4.owner) : 32'd0);
        check("dut4.owner",  32'(owner4),  32'(m4.owner));
        check("dut4.out",    32'(out4),    m4.active ? 32'(m4.fval) : 32'(nat4));
        check("dut3.forced", 32'(forced3), 32'(m3.active));
        check("dut3.gnt",    32'(gnt3),    m3.active ? (32'd1 << m3.owner) : 32'd0);
        check("dut3.owner",  32'(owner3),  32'(m3.owner));
        check("dut3.out",    32'(out3),    m3.active ? 32'(m3.fval) : 32'(nat3));
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l,
                                 input logic [15:0] v, input logic [3:0] n);
        req4 = r;
        rel4 = l;
        val4 = v;
        nat4 = n;
    endtask

    // Advance one clock: model steps on posedge, outputs checked on negedge.
    task automatic tick();
        int r4[8], l4[8], v4[8], r3[8], l3[8], v3[8];
        for (int i = 0; i < 8; i++) begin
            r4[i] = 0; l4[i] = 0; v4[i] = 0; r3[i] = 0; l3[i] = 0; v3[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            r4[i] = int'(req4[i]);
            l4[i] = int'(rel4[i]);
            v4[i] = int'(val4[i*4 +: 4]);
        end
        for (int i = 0; i < 3; i++) begin
            r3[i] = int'(req3[i]);
            l3[i] = int'(rel3[i]);
            v3[i] = int'(val3[i*4 +: 4]);
        end
        @(posedge clk);
        if (!rst_n) begin
            m4 = mreset(4);
            m3 = mreset(3);
        end else begin
            m4 = mstep(m4, 4, 2, r4, l4, v4);
            m3 = mstep(m3, 3, 1, r3, l3, v3);
        end
        @(negedge clk);
        checkOutput();
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        #1;
        m4 = mreset(4);
        m3 = mreset(3);
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int got[$];
        int rr_exp[4];
        bit prevf;

        compared = 0;
        mismatched = 0;
        rr_exp = '{0, 1, 3, 0};
        rst_n = 1'b0;
        req4 = '0; rel4 = '0; val4 = '0; nat4 = 4'h1;
        req3 = '0; rel3 = '0; val3 = '0; nat3 = 4'h6;
        m4 = mreset(4);
        m3 = mreset(3);

        // Reset and idle pass-through
        @(negedge clk);
        checkOutput();
        check("reset.out", 32'(out4), 32'h1);
        rst_n = 1'b1;
        tick();
        tick();

        // Single force, natural value hidden while forced
        applyStimulus(4'b0001, 4'b0000, 16'h0002, 4'h1);
        tick();
        check("single.out", 32'(out4), 32'h2);
        check("single.gnt", 32'(gnt4), 32'h1);
        nat4 = 4'h5;
        #1;
        checkOutput();
        check("nat_hidden.out", 32'(out4), 32'h2);

        // Early release pulse is deferred until the hold is met
        applyStimulus(4'b0001, 4'b0001, 16'h0002, 4'h1);
        tick();
        check("early.still_forced", 32'(forced4), 32'h1);
        applyStimulus(4'b0000, 4'b0000, 16'h0002, 4'h1);
        tick();
        check("early.release_forced", 32'(forced4), 32'h0);
        check("early.release_out", 32'(out4), 32'h1);
        tick();

        // Round robin order from reset with req=1011 held
        @(negedge clk);
        pulseReset();
        applyStimulus(4'b1011, 4'b1111, 16'hA9C5, 4'h0);
        prevf = forced4;
        for (int c = 0; c < 40 && got.size() < 4; c++) begin
            tick();
            if (forced4 && !prevf) got.push_back(int'(owner4));
            prevf = forced4;
        end
        check("rr.count", 32'(got.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) check("rr.order", 32'(got[k]), 32'(rr_exp[k]));
        end

        // Release owner 0, then drain to idle
        applyStimulus(4'b0000, 4'b0001, 16'h0000, 4'h0);
        tick();
        tick();
        applyStimulus(4'b0000, 4'b0000, 16'h0000, 4'h0);
        tick();
        tick();
        check("drain.idle", 32'(forced4), 32'h0);

        // Re-force tracks owner value; non-owner release ignored
        applyStimulus(4'b0100, 4'b0000, 16'h0300, 4'h0);
        tick();
        check("reforce.owner", 32'(owner4), 32'h2);
        check("reforce.out3", 32'(out4), 32'h3);
        applyStimulus(4'b0100, 4'b0000, 16'h0700, 4'h0);
        tick();
        check("reforce.out7", 32'(out4), 32'h7);
        applyStimulus(4'b0100, 4'b0010, 16'h0700, 4'h0);
        tick();
        check("nonowner_rel.forced", 32'(forced4), 32'h1);
        applyStimulus(4'b0100, 4'b0100, 16'h0900, 4'hB);
        tick();
        check("req_rel.forced", 32'(forced4), 32'h0);
        check("req_rel.out", 32'(out4), 32'hB);

        // Reset in the middle of a forced cycle
        applyStimulus(4'b0100, 4'b0000, 16'h0400, 4'hB);
        for (int c = 0; c < 4 && !forced4; c++) tick();
        check("midreset.pre", 32'(forced4), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        m4 = mreset(4);
        m3 = mreset(3);
        checkOutput();
        check("midreset.out", 32'(out4), 32'hB);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 16'h0000, 4'h0);
        tick();

        // NREQ=3 wrap and HOLD_MIN=1 immediate release
        req3 = 3'b100; rel3 = 3'b000; val3 = 12'h8AB;
        tick();
        check("wrap.owner2", 32'(owner3), 32'h2);
        req3 = 3'b000; rel3 = 3'b100;
        tick();
        check("hold1.release", 32'(forced3), 32'h0);
        rel3 = 3'b000;
        tick();
        req3 = 3'b011;
        tick();
        check("wrap.owner0", 32'(owner3), 32'h0);
        check("wrap.out", 32'(out3), 32'hB);

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            req4 = 4'($urandom);
            rel4 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            val4 = 16'($urandom);
            nat4 = 4'($urandom);
            req3 = 3'($urandom);
            rel3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'h0;
            val3 = 12'($urandom);
            nat3 = 4'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
